cla_pipe_addsub: RTL and testbench
==================================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the branch-compare (BRC) and ALU paths. It is built from GROUP-bit lookahead groups whose carries are chained. It adds subtraction, signed/unsigned compare flags, optional mid-word pipeline registers and a valid/ready handshake with backpressure. It accepts one operation per cycle and returns results in order after a fixed latency.

## Interface
- WIDTH, 32: operand width; must be a multiple of GROUP*STAGES.
- GROUP, 4: bits per lookahead group.
- STAGES, 1: pipeline depth, legal values 1 or 2; STAGES=2 splits the word at WIDTH/2.
- i_clk  in  1  single clock; everything is rising-edge.
- i_rst_n  in  1  reset, synchronous and active-low.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request this cycle.
- i_op  in  2  operation: ADD=0, SUB=1, CMP=2; 3 is reserved and behaves as CMP.
- i_a, i_b  in  WIDTH  operands.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_sum  out  WIDTH  A+B for ADD; A−B for SUB and CMP.
- o_cout  out  1  carry out of the MSB group.
- o_zero  out  1  o_sum == 0.
- o_ovf  out  1  signed overflow.
- o_lt  out  1  signed A < B (ADD: 0).
- o_ltu  out  1  unsigned A < B (ADD: 0).

## Operation
- Subtraction: B is inverted bitwise and the carry-in is 1. ADD uses B as-is with carry-in 0.
- Per bit: G = a&b', P = a^b', where b' is the possibly inverted B.
- Each group produces its sum, group-generate and group-propagate. Group carry-in is C[k+1] = GG[k] | (GP[k] & C[k]).
- o_ovf = (a[MSB] == b'[MSB]) & (sum[MSB] != a[MSB]).
- o_lt = sum[MSB] ^ o_ovf.
- o_ltu = ~o_cout. This holds for SUB and CMP only; both compare flags are forced to 0 for ADD.
- CMP is identical to SUB arithmetically. It exists so downstream logic can tag compare results; o_sum is still driven.
- STAGES=1:
  - Full carry chain, flags and output register in one cycle.
  - Output register loads when i_valid & o_ready.
- STAGES=2:
  - Stage 1 computes the low half, its carry-out, and the zero flag of the low half.
  - Stage 1 registers these together with the raw high-half operands and the op.
  - Stage 2 computes the high half from the registered carry, then merges zero (low_zero & high_zero) and the flags.
- Handshake, per stage: stage_ready = ~stage_valid | next_ready. The final next_ready is i_ready, and o_ready = stage-1 ready.
- A stage holds its data while valid && !next_ready. No bubbles are inserted when i_ready is held high.

## Timing
- Latency is STAGES cycles from an accepted request (i_valid & o_ready at edge n) to o_valid at edge n+STAGES, given no backpressure.
- Throughput is 1 operation per cycle. Up to STAGES results can be in flight.
- Reset values: every stage valid = 0 and o_valid = 0. o_ready = 1 in the cycle after reset.
- Also at reset: o_sum = 0, o_cout = 0, o_zero = 0, o_ovf = 0, o_lt = 0, o_ltu = 0.
- Reset asserted mid-operation flushes all in-flight results. Nothing already accepted is emitted after reset.
- Simultaneous output drain and input accept in the same cycle: both occur, and there is no stall.
- With i_ready held low and the pipe full, o_ready = 0. Outputs stay stable until the cycle i_ready rises.
- Wrap-around follows modulo 2^WIDTH arithmetic:
  - 0xFFFFFFFF + 1 gives sum 0 and cout 1.
  - 0 − 1 gives 0xFFFFFFFF with cout 0.
- Data outputs may hold stale values while o_valid = 0. The bench does not check them then.

## Structure
- Package cla_pkg holds:
  - op_e enum (OP_ADD, OP_SUB, OP_CMP);
  - flags_t struct (cout, zero, ovf, lt, ltu);
  - function clog2-free group count: NGROUP = WIDTH/GROUP.
- Sub-module cla_group (parametric GROUP bits): inputs a, b, cin; outputs sum, gg, gp. It is instantiated with generate, NGROUP times.
- Elaboration-time assertion: WIDTH % (GROUP*STAGES) == 0, and STAGES ∈ {1,2}.

## Test plan
- ADD, WIDTH=32, STAGES=1: A=0xFFFFFFFF, B=1 -> sum 0, cout 1, zero 1, lt/ltu 0, o_valid one cycle after accept.
- SUB: A=0x80000000, B=1 -> sum 0x7FFFFFFF, ovf 1, lt 1, ltu 0.
- CMP: A=3, B=5 -> sum 0xFFFFFFFE, lt 1, ltu 1, zero 0. CMP with A=B=0x1234 -> zero 1, lt 0, ltu 0.
- STAGES=2 streaming: 8 back-to-back random ops with i_ready=1 -> results in order, first at cycle 2, one per cycle, matching the reference model.
- Backpressure: hold i_ready=0 for 5 cycles with the pipe full -> o_ready=0, outputs stable. Release i_ready -> no loss or duplication.
- Reset mid-flight: assert i_rst_n=0 with 2 results in flight -> next cycle o_valid=0, o_ready=1, all outputs 0, and no stale result appears afterwards.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_CMP = 2'd2
    } op_e;

    typedef struct packed {
        logic cout;
        logic zero;
        logic ovf;
        logic lt;
        logic ltu;
    } flags_t;

    // Number of lookahead groups in a word.
    function automatic int ngroup(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead group: local sum plus group generate/propagate.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             gg,
    output logic             gp
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] c;
    logic             gen_acc;

    // Bit carries inside the group and the group generate, which does not depend on cin.
    always_comb begin
        g       = a & b;
        p       = a ^ b;
        c       = '0;
        c[0]    = cin;
        gen_acc = 1'b0;
        for (int i = 0; i < GROUP - 1; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        for (int i = 0; i < GROUP; i++) begin
            gen_acc = g[i] | (p[i] & gen_acc);
        end
        sum = p ^ c;
        gg  = gen_acc;
        gp  = &p;
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with compare flags and valid/ready flow control.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_zero,
    output logic             o_ovf,
    output logic             o_lt,
    output logic             o_ltu
);

    localparam int NGROUP = ngroup(WIDTH, GROUP);
    localparam int NG_LO  = NGROUP / STAGES;
    localparam int LO_W   = WIDTH / STAGES;

    if ((STAGES != 1 && STAGES != 2) || (WIDTH % (GROUP * STAGES) != 0)) begin : gen_bad_cfg
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP*STAGES and STAGES must be 1 or 2");
    end

    logic              in_sub;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_bp;
    logic [WIDTH-1:0]  sum_w;
    logic [NGROUP-1:0] grp_cin;
    logic [NGROUP-1:0] gg;
    logic [NGROUP-1:0] gp;
    logic              chain_cout;
    logic              out_ready;

    logic              fin_valid;
    logic [WIDTH-1:0]  fin_sum;
    logic              fin_cout;
    logic              fin_zero;
    logic              fin_a_msb;
    logic              fin_bp_msb;
    logic              fin_add;
    logic              fin_ovf;
    flags_t            fin_flags;
    flags_t            out_flags;

    // Anything other than ADD (including the reserved code) subtracts.
    assign in_sub = (i_op != OP_ADD);

    for (genvar k = 0; k < NGROUP; k++) begin : gen_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .a   (op_a[k*GROUP +: GROUP]),
            .b   (op_bp[k*GROUP +: GROUP]),
            .cin (grp_cin[k]),
            .sum (sum_w[k*GROUP +: GROUP]),
            .gg  (gg[k]),
            .gp  (gp[k])
        );
    end

    assign chain_cout = gg[NGROUP-1] | (gp[NGROUP-1] & grp_cin[NGROUP-1]);
    assign out_ready  = ~o_valid | i_ready;

    if (STAGES == 2) begin : gen_two
        logic            s1_valid;
        logic            s1_ready;
        logic            s1_carry;
        logic            s1_lo_zero;
        logic [LO_W-1:0] s1_lo_sum;
        logic [LO_W-1:0] s1_a_hi;
        logic [LO_W-1:0] s1_b_hi;
        logic [1:0]      s1_op;
        logic            s1_sub;
        logic            lo_cout;
        logic [LO_W-1:0] lo_bp;
        logic [LO_W-1:0] hi_bp;

        // The low half works on the live request; the high half on the registered operands.
        assign lo_bp  = in_sub ? ~i_b[LO_W-1:0] : i_b[LO_W-1:0];
        assign s1_sub = (s1_op != OP_ADD);
        assign hi_bp  = s1_sub ? ~s1_b_hi : s1_b_hi;
        assign op_a   = {s1_a_hi, i_a[LO_W-1:0]};
        assign op_bp  = {hi_bp, lo_bp};

        assign grp_cin[0] = in_sub;
        for (genvar k = 1; k < NGROUP; k++) begin : gen_chain
            if (k == NG_LO) begin : gen_cut
                assign grp_cin[k] = s1_carry;
            end else begin : gen_link
                assign grp_cin[k] = gg[k-1] | (gp[k-1] & grp_cin[k-1]);
            end
        end

        assign lo_cout  = gg[NG_LO-1] | (gp[NG_LO-1] & grp_cin[NG_LO-1]);
        assign s1_ready = ~s1_valid | out_ready;

        // Stage-1 register: low-half result, its carry and zero, plus raw high operands and op.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                s1_valid   <= 1'b0;
                s1_carry   <= 1'b0;
                s1_lo_zero <= 1'b0;
                s1_lo_sum  <= '0;
                s1_a_hi    <= '0;
                s1_b_hi    <= '0;
                s1_op      <= '0;
            end else if (s1_ready) begin
                s1_valid <= i_valid;
                if (i_valid) begin
                    s1_carry   <= lo_cout;
                    s1_lo_zero <= (sum_w[LO_W-1:0] == '0);
                    s1_lo_sum  <= sum_w[LO_W-1:0];
                    s1_a_hi    <= i_a[WIDTH-1:LO_W];
                    s1_b_hi    <= i_b[WIDTH-1:LO_W];
                    s1_op      <= i_op;
                end
            end
        end

        assign fin_valid  = s1_valid;
        assign fin_sum    = {sum_w[WIDTH-1:LO_W], s1_lo_sum};
        assign fin_cout   = chain_cout;
        assign fin_zero   = s1_lo_zero & (sum_w[WIDTH-1:LO_W] == '0);
        assign fin_a_msb  = s1_a_hi[LO_W-1];
        assign fin_bp_msb = hi_bp[LO_W-1];
        assign fin_add    = ~s1_sub;
        assign o_ready    = s1_ready;
    end else begin : gen_one
        assign op_a  = i_a;
        assign op_bp = in_sub ? ~i_b : i_b;

        assign grp_cin[0] = in_sub;
        for (genvar k = 1; k < NGROUP; k++) begin : gen_chain
            assign grp_cin[k] = gg[k-1] | (gp[k-1] & grp_cin[k-1]);
        end

        assign fin_valid  = i_valid;
        assign fin_sum    = sum_w;
        assign fin_cout   = chain_cout;
        assign fin_zero   = (sum_w == '0);
        assign fin_a_msb  = i_a[WIDTH-1];
        assign fin_bp_msb = op_bp[WIDTH-1];
        assign fin_add    = ~in_sub;
        assign o_ready    = out_ready;
    end

    assign fin_ovf = (fin_a_msb == fin_bp_msb) & (fin_sum[WIDTH-1] != fin_a_msb);

    // Merge the final flags; compare flags only mean something for SUB/CMP.
    always_comb begin
        fin_flags      = '0;
        fin_flags.cout = fin_cout;
        fin_flags.zero = fin_zero;
        fin_flags.ovf  = fin_ovf;
        fin_flags.lt   = ~fin_add & (fin_sum[WIDTH-1] ^ fin_ovf);
        fin_flags.ltu  = ~fin_add & ~fin_cout;
    end

    // Output register: loads when the consumer side has room, holds under backpressure.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid   <= 1'b0;
            o_sum     <= '0;
            out_flags <= '0;
        end else if (out_ready) begin
            o_valid <= fin_valid;
            if (fin_valid) begin
                o_sum     <= fin_sum;
                out_flags <= fin_flags;
            end
        end
    end

    assign o_cout = out_flags.cout;
    assign o_zero = out_flags.zero;
    assign o_ovf  = out_flags.ovf;
    assign o_lt   = out_flags.lt;
    assign o_ltu  = out_flags.ltu;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench: one single-stage and one two-stage instance driven from shared stimulus.
module tb_cla_pipe_addsub;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         zero;
        logic         ovf;
        logic         lt;
        logic         ltu;
    } result_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        result_t      exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic         rdy;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         r1, v1, cout1, zero1, ovf1, lt1, ltu1;
    logic [W-1:0] sum1;
    logic         r2, v2, cout2, zero2, ovf2, lt2, ltu2;
    logic [W-1:0] sum2;

    int           n_vec = 0;
    int           n_mis = 0;
    result_t      q1[$];
    result_t      q2[$];
    result_t      prev1, prev2;
    logic         hold1 = 1'b0;
    logic         hold2 = 1'b0;
    vec_t         tbl[11];

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(W), .GROUP(4), .STAGES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(r1), .i_op(op),
        .i_a(a), .i_b(b), .o_valid(v1), .i_ready(rdy), .o_sum(sum1), .o_cout(cout1),
        .o_zero(zero1), .o_ovf(ovf1), .o_lt(lt1), .o_ltu(ltu1)
    );

    cla_pipe_addsub #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(r2), .i_op(op),
        .i_a(a), .i_b(b), .o_valid(v2), .i_ready(rdy), .o_sum(sum2), .o_cout(cout2),
        .o_zero(zero2), .o_ovf(ovf2), .o_lt(lt2), .o_ltu(ltu2)
    );

    // Reference: plain modular and signed/unsigned integer arithmetic.
    function automatic result_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        result_t r;
        longint  sx, sy, sr;
        logic    is_add;
        is_add = (o == 2'd0);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (is_add) begin
            r.sum  = x + y;
            r.cout = ((longint'(x) + longint'(y)) >= 64'sh1_0000_0000);
            sr     = sx + sy;
        end else begin
            r.sum  = x - y;
            r.cout = (x >= y);
            sr     = sx - sy;
        end
        r.zero = (r.sum == '0);
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.lt   = !is_add && (sx < sy);
        r.ltu  = !is_add && (x < y);
        return r;
    endfunction

    function automatic vec_t mkVec(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] s, input logic c, input logic z,
                                   input logic v, input logic l, input logic lu);
        vec_t t;
        t.op = o; t.a = x; t.b = y;
        t.exp.sum = s; t.exp.cout = c; t.exp.zero = z; t.exp.ovf = v; t.exp.lt = l; t.exp.ltu = lu;
        return t;
    endfunction

    function automatic result_t res1();
        result_t r;
        r.sum = sum1; r.cout = cout1; r.zero = zero1; r.ovf = ovf1; r.lt = lt1; r.ltu = ltu1;
        return r;
    endfunction

    function automatic result_t res2();
        result_t r;
        r.sum = sum2; r.cout = cout2; r.zero = zero2; r.ovf = ovf2; r.lt = lt2; r.ltu = ltu2;
        return r;
    endfunction

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        valid = v; op = o; a = x; b = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_mis++;
        $display("[TB] FAIL %s: result with no outstanding request", name);
    endtask

    // Scoreboards: sample mid-cycle what the next rising edge will transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            q2.delete();
            hold1 = 1'b0;
            hold2 = 1'b0;
        end else begin
            if (hold1) begin
                checkOutput("hold1_valid", 64'(v1), 64'd1);
                checkOutput("hold1_data", 64'(res1()), 64'(prev1));
            end
            if (hold2) begin
                checkOutput("hold2_valid", 64'(v2), 64'd1);
                checkOutput("hold2_data", 64'(res2()), 64'(prev2));
            end
            if (v1 && rdy) begin
                if (q1.size() == 0) unexpected("extra1");
                else checkOutput("sb1", 64'(res1()), 64'(q1.pop_front()));
            end
            if (v2 && rdy) begin
                if (q2.size() == 0) unexpected("extra2");
                else checkOutput("sb2", 64'(res2()), 64'(q2.pop_front()));
            end
            if (valid && r1) q1.push_back(model(op, a, b));
            if (valid && r2) q2.push_back(model(op, a, b));
            hold1 = v1 && !rdy;
            hold2 = v2 && !rdy;
            prev1 = res1();
            prev2 = res2();
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: bench did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0]  = mkVec(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0, 0);
        tbl[1]  = mkVec(2'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 0, 1, 1, 0);
        tbl[2]  = mkVec(2'd2, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 0, 0, 0, 1, 1);
        tbl[3]  = mkVec(2'd2, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1, 1, 0, 0, 0);
        tbl[4]  = mkVec(2'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 1, 1);
        tbl[5]  = mkVec(2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0, 0);
        tbl[6]  = mkVec(2'd3, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1, 0, 0, 0, 0);
        tbl[7]  = mkVec(2'd0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 0, 0, 0, 0, 0);
        tbl[8]  = mkVec(2'd1, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1, 0, 0, 0, 0);
        tbl[9]  = mkVec(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1, 1, 0, 0);
        tbl[10] = mkVec(2'd2, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 0, 1);

        rst_n = 1'b0;
        rdy   = 1'b1;
        applyStimulus(0, 2'd0, '0, '0);
        repeat (3) step();
        checkOutput("rst_valid1", 64'(v1), 64'd0);
        checkOutput("rst_valid2", 64'(v2), 64'd0);
        checkOutput("rst_res1", 64'(res1()), 64'd0);
        checkOutput("rst_res2", 64'(res2()), 64'd0);
        rst_n = 1'b1;
        step();
        checkOutput("rst_ready1", 64'(r1), 64'd1);
        checkOutput("rst_ready2", 64'(r2), 64'd1);

        // Directed table: latency and values for both pipeline depths.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1, tbl[i].op, tbl[i].a, tbl[i].b);
            step();
            applyStimulus(0, 2'd0, '0, '0);
            checkOutput($sformatf("vec%0d_lat1", i), 64'(v1), 64'd1);
            checkOutput($sformatf("vec%0d_early2", i), 64'(v2), 64'd0);
            checkOutput($sformatf("vec%0d_res1", i), 64'(res1()), 64'(tbl[i].exp));
            step();
            checkOutput($sformatf("vec%0d_drain1", i), 64'(v1), 64'd0);
            checkOutput($sformatf("vec%0d_lat2", i), 64'(v2), 64'd1);
            checkOutput($sformatf("vec%0d_res2", i), 64'(res2()), 64'(tbl[i].exp));
            step();
        end

        // Eight back-to-back requests with the consumer always ready.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 2'($urandom_range(0, 3)), randOperand(), randOperand());
            step();
            checkOutput("stream_v1", 64'(v1), 64'd1);
            checkOutput("stream_v2", 64'(v2), 64'(k >= 1));
            checkOutput("stream_r2", 64'(r2), 64'd1);
        end
        applyStimulus(0, 2'd0, '0, '0);
        step();
        checkOutput("stream_tail_v1", 64'(v1), 64'd0);
        checkOutput("stream_tail_v2", 64'(v2), 64'd1);
        step();
        checkOutput("stream_end_v2", 64'(v2), 64'd0);
        checkOutput("stream_q1", 64'(q1.size()), 64'd0);
        checkOutput("stream_q2", 64'(q2.size()), 64'd0);

        // Backpressure: fill both pipes, stall five cycles with a request waiting, then release.
        rdy = 1'b0;
        applyStimulus(1, 2'($urandom_range(0, 3)), randOperand(), randOperand());
        step();
        checkOutput("bp_r1_full", 64'(r1), 64'd0);
        checkOutput("bp_r2_room", 64'(r2), 64'd1);
        applyStimulus(1, 2'($urandom_range(0, 3)), randOperand(), randOperand());
        step();
        applyStimulus(1, 2'($urandom_range(0, 3)), randOperand(), randOperand());
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput("bp_r1", 64'(r1), 64'd0);
            checkOutput("bp_r2", 64'(r2), 64'd0);
            checkOutput("bp_v1", 64'(v1), 64'd1);
            checkOutput("bp_v2", 64'(v2), 64'd1);
        end
        rdy = 1'b1;
        step();
        applyStimulus(0, 2'd0, '0, '0);
        repeat (3) step();
        checkOutput("bp_q1", 64'(q1.size()), 64'd0);
        checkOutput("bp_q2", 64'(q2.size()), 64'd0);

        // Reset with two results in flight in the two-stage pipe.
        applyStimulus(1, 2'($urandom_range(0, 3)), randOperand(), randOperand());
        step();
        applyStimulus(1, 2'($urandom_range(0, 3)), randOperand(), randOperand());
        step();
        rst_n = 1'b0;
        applyStimulus(0, 2'd0, '0, '0);
        step();
        checkOutput("flush_v1", 64'(v1), 64'd0);
        checkOutput("flush_v2", 64'(v2), 64'd0);
        checkOutput("flush_r1", 64'(r1), 64'd1);
        checkOutput("flush_r2", 64'(r2), 64'd1);
        checkOutput("flush_res1", 64'(res1()), 64'd0);
        checkOutput("flush_res2", 64'(res2()), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("post_flush_v1", 64'(v1), 64'd0);
            checkOutput("post_flush_v2", 64'(v2), 64'd0);
        end

        // Random traffic with random backpressure; scoreboards check every transfer.
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), randOperand(), randOperand());
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        applyStimulus(0, 2'd0, '0, '0);
        rdy = 1'b1;
        repeat (6) step();
        checkOutput("final_q1", 64'(q1.size()), 64'd0);
        checkOutput("final_q2", 64'(q2.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
